rt_ibex_hws_irq_sequencer: RTL and testbench
============================================

// Module: rt_ibex_hws_irq_sequencer
// PURPOSE
// Interrupt-context sequencer for RT-IBEX. It decides when the HW stacking unit runs
// a SAVE or RESTORE, and drives that unit's start/mode/ack handshake. It tracks
// nested-interrupt levels and performs tail-chaining on mret (skips RESTORE+SAVE).
// It sits between the interrupt source, the ID/controller (mret, stall) and the stacking unit.
// PARAMETERS
// MAX_NEST  4  maximum nesting depth (level-stack entries); must be >= 1
// LVL_W     8  interrupt level width; level 0 means "no interrupt"
// ID_W      5  interrupt id width
// PORTS
// clk_i           in   1      clock
// rst_ni          in   1      async reset, active-low
// irq_req_i       in   1      interrupt pending (level), qualified by id/level
// irq_id_i        in   ID_W   pending interrupt id
// irq_level_i     in   LVL_W  pending interrupt level
// irq_ack_o       out  1      1-cycle pulse: irq_id_i taken this cycle
// mret_i          in   1      1-cycle pulse: mret accepted in ID
// core_stall_o    out  1      hold fetch/ID while a stacking op is in progress
// handler_go_o    out  1      1-cycle pulse: redirect to handler of handler_id_o
// handler_id_o    out  ID_W   id of the handler being entered (registered)
// return_go_o     out  1      1-cycle pulse: restore complete, resume at mepc
// hws_start_o     out  1      1-cycle start pulse to stacking unit
// hws_mode_o      out  hw_stacking_mode  SAVE/RESTORE; stable from start to ack
// hws_ack_o       out  1      1-cycle ack of stacking done
// hws_done_i      in   1      stacking unit done (registered, held until ack+1)
// cur_level_o     out  LVL_W  level of running handler (0 when idle)
// depth_o         out  $clog2(MAX_NEST+1)  current nesting depth
// err_o           out  1      1-cycle pulse: mret at depth 0
// BEHAVIOUR
// - Reset: all outputs 0, hws_mode_o=SAVE, FSM IDLE, depth 0, level stack cleared.
// - FSM states: IDLE, SAVE_REQ, SAVE_WAIT, HS_ACK, RUN, RST_REQ, RST_WAIT.
// - IDLE: if irq_req_i && irq_level_i>0 -> irq_ack_o=1 and latch id/level -> SAVE_REQ.
// - SAVE_REQ: hws_start_o=1, hws_mode_o=SAVE -> SAVE_WAIT.
// - SAVE_WAIT: wait for hws_done_i; on done: hws_ack_o=1, push latched level,
//   depth++, -> HS_ACK.
// - HS_ACK: one cooldown cycle with hws_done_i ignored (done deasserts one cycle
//   after ack). Then: after SAVE, handler_go_o=1 -> RUN; after RESTORE, pop,
//   depth--, return_go_o=1 -> RUN if depth>0, else IDLE.
// - core_stall_o=1 in SAVE_REQ, SAVE_WAIT, RST_REQ, RST_WAIT and HS_ACK.
// - RUN, preemption: irq_req_i && irq_level_i>cur_level && depth<MAX_NEST ->
//   ack, latch -> SAVE_REQ. At depth==MAX_NEST preemption is masked (no ack).
// - RUN, mret_i with tail-chain: prev = stack[depth-2], or 0 if depth==1.
//   If irq_req_i && irq_level_i>prev: irq_ack_o=1, replace top entry with the new
//   level, handler_go_o next cycle. No stacking op and no stall; depth unchanged.
// - RUN, mret_i otherwise -> RST_REQ: hws_start_o=1, hws_mode_o=RESTORE -> RST_WAIT.
//   On done: ack -> HS_ACK.
// - mret_i and a preempting irq in the same cycle: mret has priority and is
//   evaluated for tail-chain.
// - mret_i outside RUN: ignored. If depth==0, err_o pulses.
// - irq_req_i drop after ack: no effect (id/level already latched).
// - hws_mode_o changes only on a hws_start_o cycle. hws_start_o is never reasserted
//   before the ack+cooldown cycle.
// - cur_level_o = stack top (0 if depth 0). depth never wraps; pushes are gated
//   by the MAX_NEST check.
// - Reset mid-operation: async return to IDLE, all outputs 0. The stacking unit
//   shares rst_ni, so no handshake is left pending.
// TESTING
// - Idle, irq id=3 lvl=5, done 12 cyc after start -> ack@T0, start(SAVE)@T1,
//   hws_ack at done, handler_go 2 cyc later, cur_level=5, depth=1.
// - In RUN lvl5, irq lvl 7 -> second SAVE, depth=2. mret, no irq -> RESTORE,
//   return_go, depth=1, cur_level=5.
// - depth1 lvl5, mret with irq lvl3 pending -> tail-chain: no hws_start,
//   irq_ack same cycle, handler_go next cycle, cur_level=3, depth=1.
// - MAX_NEST=4 full, irq lvl 200 > top -> no irq_ack, no start; after one mret the
//   irq is taken (tail-chain).
// - mret while idle -> err_o 1-cycle pulse, state unchanged. hws_done_i held 1 extra
//   cycle after ack -> no second ack.
// - rst_ni low during SAVE_WAIT -> all outputs 0 immediately; a fresh irq after
//   release takes the normal SAVE path with depth=1.

Source files
------------

// File: rtl/rt_ibex_hws_irq_sequencer.sv
// rt_ibex_hws_irq_sequencer
//
// Interrupt-context sequencer for RT-IBEX. It decides when the hardware stacking
// unit performs a SAVE (interrupt entry) or a RESTORE (interrupt return) and runs
// that unit's start/mode/ack handshake. It also keeps a small stack of the levels
// of nested handlers. On mret it can tail-chain straight into a pending interrupt,
// which skips the RESTORE+SAVE pair.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   irq_req_i/id/level     pending interrupt (level 0 = no interrupt)
//   irq_ack_o              pulse: pending interrupt has been taken
//   mret_i                 pulse: mret accepted in ID
//   core_stall_o           hold fetch/ID while a stacking op is in flight
//   handler_go_o/id_o      pulse: redirect to the handler of handler_id_o
//   return_go_o            pulse: restore finished, resume at mepc
//   hws_start_o/mode_o     start pulse and SAVE(0)/RESTORE(1) mode to stacking unit
//   hws_ack_o, hws_done_i  completion handshake with the stacking unit
//   cur_level_o, depth_o   level of running handler and current nesting depth
//   err_o                  pulse: mret seen with no active handler
module rt_ibex_hws_irq_sequencer #(
  parameter int MAX_NEST = 4,
  parameter int LVL_W    = 8,
  parameter int ID_W     = 5,
  localparam int DEPTH_W = $clog2(MAX_NEST + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               irq_req_i,
  input  logic [ID_W-1:0]    irq_id_i,
  input  logic [LVL_W-1:0]   irq_level_i,
  output logic               irq_ack_o,
  input  logic               mret_i,
  output logic               core_stall_o,
  output logic               handler_go_o,
  output logic [ID_W-1:0]    handler_id_o,
  output logic               return_go_o,
  output logic               hws_start_o,
  output logic               hws_mode_o,
  output logic               hws_ack_o,
  input  logic               hws_done_i,
  output logic [LVL_W-1:0]   cur_level_o,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               err_o
);

  localparam int   IDX_W        = (MAX_NEST > 1) ? $clog2(MAX_NEST) : 1;
  localparam logic MODE_SAVE    = 1'b0;
  localparam logic MODE_RESTORE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_REQ,
    ST_SAVE_WAIT,
    ST_HS_ACK,
    ST_RUN,
    ST_RST_REQ,
    ST_RST_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [LVL_W-1:0]    stack_q [MAX_NEST];
  logic [LVL_W-1:0]    stack_d [MAX_NEST];
  logic [ID_W-1:0]     lat_id_q, lat_id_d;
  logic [LVL_W-1:0]    lat_lvl_q, lat_lvl_d;
  logic                chain_q, chain_d;

  logic                irq_ack_q, irq_ack_d;
  logic                stall_q, stall_d;
  logic                go_q, go_d;
  logic [ID_W-1:0]     hid_q, hid_d;
  logic                ret_q, ret_d;
  logic                start_q, start_d;
  logic                mode_q, mode_d;
  logic                hack_q, hack_d;
  logic                err_q, err_d;

  logic [IDX_W-1:0]    top_idx, prev_idx, push_idx;
  logic [LVL_W-1:0]    cur_level, prev_level;
  logic                irq_valid, can_push;

  assign top_idx    = IDX_W'(depth_q - DEPTH_W'(1));
  assign prev_idx   = IDX_W'(depth_q - DEPTH_W'(2));
  assign push_idx   = IDX_W'(depth_q);
  assign cur_level  = (depth_q == '0) ? '0 : stack_q[top_idx];
  // Level the core would return to if the current handler exits.
  assign prev_level = (depth_q <= DEPTH_W'(1)) ? '0 : stack_q[prev_idx];
  assign irq_valid  = irq_req_i && (irq_level_i != '0);
  assign can_push   = depth_q < DEPTH_W'(MAX_NEST);

  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    stack_d   = stack_q;
    lat_id_d  = lat_id_q;
    lat_lvl_d = lat_lvl_q;
    chain_d   = chain_q;
    irq_ack_d = 1'b0;
    go_d      = 1'b0;
    hid_d     = hid_q;
    ret_d     = 1'b0;
    start_d   = 1'b0;
    mode_d    = mode_q;
    hack_d    = 1'b0;
    // In RUN the depth is always non-zero, so this only fires outside RUN.
    err_d     = mret_i && (depth_q == '0);

    unique case (state_q)
      ST_IDLE: begin
        if (irq_valid) begin
          irq_ack_d = 1'b1;
          lat_id_d  = irq_id_i;
          lat_lvl_d = irq_level_i;
          state_d   = ST_SAVE_REQ;
        end
      end
      ST_SAVE_REQ: begin
        start_d = 1'b1;
        mode_d  = MODE_SAVE;
        state_d = ST_SAVE_WAIT;
      end
      ST_SAVE_WAIT: begin
        if (hws_done_i) begin
          hack_d = 1'b1;
          if (can_push) begin
            stack_d[push_idx] = lat_lvl_q;
            depth_d           = depth_q + DEPTH_W'(1);
          end
          state_d = ST_HS_ACK;
        end
      end
      ST_HS_ACK: begin
        // hws_done_i may still be high here; it is deliberately not looked at.
        if (mode_q == MODE_SAVE) begin
          go_d    = 1'b1;
          hid_d   = lat_id_q;
          state_d = ST_RUN;
        end else begin
          if (depth_q != '0) begin
            stack_d[top_idx] = '0;
            depth_d          = depth_q - DEPTH_W'(1);
          end
          ret_d   = 1'b1;
          state_d = (depth_q > DEPTH_W'(1)) ? ST_RUN : ST_IDLE;
        end
      end
      ST_RUN: begin
        if (chain_q) begin
          // Second half of a tail-chain: enter the new handler.
          chain_d = 1'b0;
          go_d    = 1'b1;
          hid_d   = lat_id_q;
        end else if (mret_i) begin
          if (irq_req_i && (irq_level_i > prev_level)) begin
            // Tail-chain: the saved context stays on the stack, only the
            // level of the top entry changes.
            irq_ack_d        = 1'b1;
            lat_id_d         = irq_id_i;
            stack_d[top_idx] = irq_level_i;
            chain_d          = 1'b1;
          end else begin
            state_d = ST_RST_REQ;
          end
        end else if (irq_valid && (irq_level_i > cur_level) && can_push) begin
          irq_ack_d = 1'b1;
          lat_id_d  = irq_id_i;
          lat_lvl_d = irq_level_i;
          state_d   = ST_SAVE_REQ;
        end
      end
      ST_RST_REQ: begin
        start_d = 1'b1;
        mode_d  = MODE_RESTORE;
        state_d = ST_RST_WAIT;
      end
      ST_RST_WAIT: begin
        if (hws_done_i) begin
          hack_d  = 1'b1;
          state_d = ST_HS_ACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    stall_d = (state_d == ST_SAVE_REQ) || (state_d == ST_SAVE_WAIT) ||
              (state_d == ST_HS_ACK)   || (state_d == ST_RST_REQ)   ||
              (state_d == ST_RST_WAIT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      depth_q   <= '0;
      for (int i = 0; i < MAX_NEST; i++) stack_q[i] <= '0;
      lat_id_q  <= '0;
      lat_lvl_q <= '0;
      chain_q   <= 1'b0;
      irq_ack_q <= 1'b0;
      stall_q   <= 1'b0;
      go_q      <= 1'b0;
      hid_q     <= '0;
      ret_q     <= 1'b0;
      start_q   <= 1'b0;
      mode_q    <= MODE_SAVE;
      hack_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      stack_q   <= stack_d;
      lat_id_q  <= lat_id_d;
      lat_lvl_q <= lat_lvl_d;
      chain_q   <= chain_d;
      irq_ack_q <= irq_ack_d;
      stall_q   <= stall_d;
      go_q      <= go_d;
      hid_q     <= hid_d;
      ret_q     <= ret_d;
      start_q   <= start_d;
      mode_q    <= mode_d;
      hack_q    <= hack_d;
      err_q     <= err_d;
    end
  end

  assign irq_ack_o    = irq_ack_q;
  assign core_stall_o = stall_q;
  assign handler_go_o = go_q;
  assign handler_id_o = hid_q;
  assign return_go_o  = ret_q;
  assign hws_start_o  = start_q;
  assign hws_mode_o   = mode_q;
  assign hws_ack_o    = hack_q;
  assign cur_level_o  = cur_level;
  assign depth_o      = depth_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_rt_ibex_hws_irq_sequencer.sv
// Testbench for rt_ibex_hws_irq_sequencer: transaction-level model with an
// expected-event scoreboard, a behavioural stacking unit and random stimulus.
module tb_rt_ibex_hws_irq_sequencer;

  localparam int MAX_NEST = 4;
  localparam int LVL_W    = 8;
  localparam int ID_W     = 5;
  localparam int DEPTH_W  = $clog2(MAX_NEST + 1);

  localparam int K_IACK  = 1;
  localparam int K_START = 2;
  localparam int K_HACK  = 3;
  localparam int K_GO    = 4;
  localparam int K_RET   = 5;
  localparam int K_ERR   = 6;

  logic               clk_i;
  logic               rst_ni;
  logic               irq_req_i;
  logic [ID_W-1:0]    irq_id_i;
  logic [LVL_W-1:0]   irq_level_i;
  logic               irq_ack_o;
  logic               mret_i;
  logic               core_stall_o;
  logic               handler_go_o;
  logic [ID_W-1:0]    handler_id_o;
  logic               return_go_o;
  logic               hws_start_o;
  logic               hws_mode_o;
  logic               hws_ack_o;
  logic               hws_done_i;
  logic [LVL_W-1:0]   cur_level_o;
  logic [DEPTH_W-1:0] depth_o;
  logic               err_o;

  rt_ibex_hws_irq_sequencer #(
    .MAX_NEST(MAX_NEST), .LVL_W(LVL_W), .ID_W(ID_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .irq_req_i(irq_req_i), .irq_id_i(irq_id_i), .irq_level_i(irq_level_i),
    .irq_ack_o(irq_ack_o), .mret_i(mret_i), .core_stall_o(core_stall_o),
    .handler_go_o(handler_go_o), .handler_id_o(handler_id_o),
    .return_go_o(return_go_o), .hws_start_o(hws_start_o),
    .hws_mode_o(hws_mode_o), .hws_ack_o(hws_ack_o), .hws_done_i(hws_done_i),
    .cur_level_o(cur_level_o), .depth_o(depth_o), .err_o(err_o)
  );

  typedef struct {
    int kind;
    int id;
    int mode;
    int cur;
    int depth;
    int stall;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   stk[$];      // model of the nested handler levels, bottom first
  int   checks;
  int   failures;
  int   cyc;
  int   last_cyc;
  int   unit_delay;  // 0 = random done latency
  int   unit_extra;  // 1 = always hold done one extra cycle

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic void push_exp(input int kind, input int id, input int mode,
                                   input int cur, input int depth, input int stall,
                                   input int gap);
    exp_t e;
    e.kind = kind; e.id = id; e.mode = mode; e.cur = cur;
    e.depth = depth; e.stall = stall; e.gap = gap;
    exp_q.push_back(e);
  endfunction

  function automatic int top_lvl();
    return (stk.size() == 0) ? 0 : stk[stk.size()-1];
  endfunction

  function automatic int prev_lvl();
    return (stk.size() <= 1) ? 0 : stk[stk.size()-2];
  endfunction

  // Monitor: every pulse the DUT shows is matched against the next expected event.
  initial begin
    last_cyc = 0;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        int n, kind, gap;
        bit ok;
        exp_t e;
        n = int'(irq_ack_o) + int'(hws_start_o) + int'(hws_ack_o) +
            int'(handler_go_o) + int'(return_go_o) + int'(err_o);
        if (n > 0) begin
          kind = irq_ack_o ? K_IACK : hws_start_o ? K_START : hws_ack_o ? K_HACK :
                 handler_go_o ? K_GO : return_go_o ? K_RET : K_ERR;
          gap = cyc - last_cyc;
          checks++;
          if (n > 1) begin
            failures++;
            $display("FAIL multi_pulse cyc=%0d got=%0d pulses required=1", cyc, n);
          end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event cyc=%0d got kind=%0d required none", cyc, kind);
          end else begin
            e = exp_q.pop_front();
            ok = (kind == e.kind) && (int'(depth_o) == e.depth) &&
                 (int'(cur_level_o) == e.cur) && (int'(core_stall_o) == e.stall);
            if (e.kind == K_GO && int'(handler_id_o) != e.id) ok = 1'b0;
            if ((e.kind == K_START || e.kind == K_HACK) && int'(hws_mode_o) != e.mode) ok = 1'b0;
            if (e.gap >= 0 && gap != e.gap) ok = 1'b0;
            if (!ok) begin
              failures++;
              $display("FAIL event cyc=%0d kind got=%0d req=%0d depth got=%0d req=%0d cur got=%0d req=%0d stall got=%0d req=%0d id got=%0d req=%0d mode got=%0d req=%0d gap got=%0d req=%0d",
                       cyc, kind, e.kind, depth_o, e.depth, cur_level_o, e.cur,
                       core_stall_o, e.stall, handler_id_o, e.id, hws_mode_o, e.mode,
                       gap, e.gap);
            end
          end
          last_cyc = cyc;
        end
      end
    end
  end

  // Behavioural stacking unit: done after a latency, held until one cycle past ack.
  initial begin
    int phase, cnt, wcnt;
    bit extra;
    phase = 0; cnt = 0; wcnt = 0; extra = 1'b0;
    hws_done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        phase = 0;
        hws_done_i = 1'b0;
      end else begin
        case (phase)
          0: if (hws_start_o) begin
               cnt   = (unit_delay > 0) ? unit_delay : $urandom_range(1, 12);
               extra = (unit_extra != 0) ? 1'b1 : 1'($urandom_range(0, 1));
               phase = 1;
             end
          1: begin
               if (hws_start_o) begin
                 failures++;
                 $display("FAIL start_while_busy cyc=%0d got start=1 required 0", cyc);
               end
               cnt--;
               if (cnt <= 0) begin
                 hws_done_i = 1'b1;
                 wcnt = 0;
                 phase = 2;
               end
             end
          2: begin
               if (hws_ack_o) phase = 3;
               else begin
                 wcnt++;
                 if (wcnt > 40) begin
                   failures++;
                   $display("FAIL ack_timeout cyc=%0d got no hws_ack required one", cyc);
                   hws_done_i = 1'b0;
                   phase = 0;
                 end
               end
             end
          3: if (extra) phase = 4;
             else begin
               hws_done_i = 1'b0;
               phase = 0;
             end
          default: begin
               hws_done_i = 1'b0;
               phase = 0;
             end
        endcase
      end
    end
  end

  task automatic wait_quiet();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL events_outstanding cyc=%0d got=%0d required=0", cyc, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic do_irq(input int id, input int lvl, input bit keep);
    int  d, top;
    bit  taken, got;
    d = stk.size();
    top = top_lvl();
    taken = (lvl > 0) && (lvl > top) && (d < MAX_NEST);
    @(negedge clk_i);
    if (taken) begin
      push_exp(K_IACK,  id, 0, top, d,     1, -1);
      push_exp(K_START, id, 0, top, d,     1,  1);
      push_exp(K_HACK,  id, 0, lvl, d + 1, 1, -1);
      push_exp(K_GO,    id, 0, lvl, d + 1, 0,  1);
      stk.push_back(lvl);
    end
    irq_req_i = 1'b1;
    irq_id_i = ID_W'(id);
    irq_level_i = LVL_W'(lvl);
    if (taken) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk_i);
        if (irq_ack_o) got = 1'b1;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL irq_ack_timeout cyc=%0d got no ack required ack", cyc);
      end
      irq_req_i = 1'b0;
    end else begin
      repeat (5) @(negedge clk_i);
      if (!keep) irq_req_i = 1'b0;
    end
    wait_quiet();
  endtask

  task automatic do_mret(input bit with_irq, input int id, input int lvl);
    int d, top;
    d = stk.size();
    top = top_lvl();
    @(negedge clk_i);
    if (d == 0) begin
      push_exp(K_ERR, 0, 0, 0, 0, 0, -1);
    end else if (with_irq && lvl > prev_lvl()) begin
      push_exp(K_IACK, id, 0, lvl, d, 0, -1);
      push_exp(K_GO,   id, 0, lvl, d, 0,  1);
      stk[d-1] = lvl;
    end else begin
      void'(stk.pop_back());
      push_exp(K_START, 0, 1, top, d, 1, -1);
      push_exp(K_HACK,  0, 1, top, d, 1, -1);
      push_exp(K_RET,   0, 1, top_lvl(), d - 1, 0, 1);
    end
    mret_i = 1'b1;
    if (with_irq && d != 0) begin
      irq_req_i = 1'b1;
      irq_id_i = ID_W'(id);
      irq_level_i = LVL_W'(lvl);
    end
    @(negedge clk_i);
    mret_i = 1'b0;
    wait_quiet();
    irq_req_i = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    logic [23:0] v;
    v = {irq_ack_o, core_stall_o, handler_go_o, handler_id_o, return_go_o,
         hws_start_o, hws_mode_o, hws_ack_o, cur_level_o, depth_o, err_o};
    checks++;
    if (v != '0) begin
      failures++;
      $display("FAIL %s got=%h required=000000", name, v);
    end
  endtask

  initial begin
    bit got;
    checks = 0; failures = 0;
    unit_delay = 0; unit_extra = 0;
    rst_ni = 1'b0; irq_req_i = 1'b0; irq_id_i = '0; irq_level_i = '0; mret_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset_outputs");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check_all_zero("post_reset_idle");

    // mret while idle: error pulse only
    do_mret(1'b0, 0, 0);

    // Entry, preemption, restore with done held one extra cycle, tail-chain
    unit_delay = 12;
    do_irq(3, 5, 1'b0);
    unit_delay = 0;
    do_irq(9, 7, 1'b0);
    unit_extra = 1;
    do_mret(1'b0, 0, 0);
    unit_extra = 0;
    do_mret(1'b1, 4, 3);

    // Fill to MAX_NEST, masked preemption, then tail-chain into it
    do_irq(10, 10, 1'b0);
    do_irq(11, 20, 1'b0);
    do_irq(12, 30, 1'b0);
    do_irq(13, 200, 1'b1);
    do_mret(1'b1, 13, 200);

    for (int it = 0; it < 70; it++) begin
      int r, lv, idv;
      r = $urandom_range(0, 9);
      lv = $urandom_range(0, 255);
      idv = $urandom_range(0, 31);
      if (stk.size() == 0) begin
        if (r < 8) do_irq(idv, lv, 1'b0);
        else do_mret(1'b0, 0, 0);
      end else if (r < 4) do_irq(idv, lv, 1'b0);
      else if (r < 7) do_mret(1'b0, 0, 0);
      else do_mret(1'b1, idv, lv);
    end
    while (stk.size() > 0) do_mret(1'b0, 0, 0);

    checks++;
    if (depth_o != '0 || cur_level_o != '0) begin
      failures++;
      $display("FAIL unwound got depth=%0d cur=%0d required 0 0", depth_o, cur_level_o);
    end

    // Reset in the middle of a SAVE, then a fresh interrupt
    unit_delay = 12;
    @(negedge clk_i);
    push_exp(K_IACK,  7, 0, 0, 0, 1, -1);
    push_exp(K_START, 7, 0, 0, 0, 1,  1);
    irq_req_i = 1'b1; irq_id_i = ID_W'(7); irq_level_i = LVL_W'(5);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      if (hws_start_o) got = 1'b1;
    end
    irq_req_i = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL start_timeout cyc=%0d got no start required start", cyc);
    end
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("reset_mid_save");
    exp_q.delete();
    stk.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    unit_delay = 0;
    do_irq(8, 9, 1'b0);
    do_mret(1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
